// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: architectural register numbers, the
// default datapath width and the RegDst encoding used by the destination mux
// that feeds the register file write port.
package mips_pkg;

    // Default architectural datapath width
    localparam int MIPS_DATA_W = 32;

    // Number of general-purpose registers and address width
    localparam int NUM_REGS = 32;
    localparam int REG_AW   = 5;

    // Architectural register numbers with special meaning
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_AW-1:0] REG_GP   = 5'd28;
    localparam logic [REG_AW-1:0] REG_SP   = 5'd29;
    localparam logic [REG_AW-1:0] REG_RA   = 5'd31;

    // Write-destination select driven by the RegDst/Jump control
    typedef enum logic [1:0] {
        REGDST_RT = 2'b00,
        REGDST_RD = 2'b01,
        REGDST_RA = 2'b10
    } regdst_e;

    // True when the address names the hardwired $zero register
    function automatic logic is_zero_reg(input logic [REG_AW-1:0] addr);
        return (addr == REG_ZERO);
    endfunction

    // Destination register chosen by the RegDst encoding
    function automatic logic [REG_AW-1:0] regdst_sel(
        input regdst_e           sel,
        input logic [REG_AW-1:0] rt,
        input logic [REG_AW-1:0] rd
    );
        logic [REG_AW-1:0] dst;
        dst = rt;
        case (sel)
            REGDST_RT: dst = rt;
            REGDST_RD: dst = rd;
            REGDST_RA: dst = REG_RA;
            default:   dst = rt;
        endcase
        return dst;
    endfunction

endpackage

// File: rtl/mips_reg_read_port.sv
// One combinational read port of the register file. Selects a stored
// register, optionally replaces it with the write-port data when the write
// targets the same address this cycle, and always returns zero for $zero.
module mips_reg_read_port
    import mips_pkg::*;
#(
    parameter int DATA_W = MIPS_DATA_W
) (
    input  logic [REG_AW-1:0] addr_i,
    input  logic [DATA_W-1:0] regs_i [NUM_REGS],
    input  logic              byp_en_i,
    input  logic [REG_AW-1:0] byp_addr_i,
    input  logic [DATA_W-1:0] byp_data_i,
    output logic [DATA_W-1:0] data_o
);

    logic byp_hit;

    // Forwarding is only meaningful for a real (non-$zero) committed write
    assign byp_hit = byp_en_i && (byp_addr_i == addr_i) && !is_zero_reg(addr_i);

    // Read mux: $zero forced low, then forwarded data, then stored value
    always_comb begin
        data_o = regs_i[addr_i];
        if (is_zero_reg(addr_i)) begin
            data_o = '0;
        end else if (byp_hit) begin
            data_o = byp_data_i;
        end
    end

endmodule

// File: rtl/mips_reg_file.sv
// 32 x DATA_W MIPS general-purpose register file with two combinational read
// ports, one synchronous write port, a non-forwarding debug read port for the
// board display, and last-write / saturating write-count debug state.
module mips_reg_file
    import mips_pkg::*;
#(
    parameter int              DATA_W  = MIPS_DATA_W,
    parameter logic [31:0]     SP_INIT = 32'h0000_3FFC,
    parameter logic [31:0]     GP_INIT = 32'h0000_1800,
    parameter bit              BYPASS  = 1'b1,
    parameter int              CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        rs_addr,
    input  logic [4:0]        rt_addr,
    input  logic [4:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              RegWrite,
    input  logic [4:0]        dbg_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] dbg_data,
    output logic [4:0]        last_wr_addr,
    output logic [DATA_W-1:0] last_wr_data,
    output logic [CNT_W-1:0]  wr_count
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [4:0]        last_addr_q, last_addr_d;
    logic [DATA_W-1:0] last_data_q, last_data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic wr_commit;
    logic byp_en;

    // Power-on / reset contents: $gp and $sp start at their stack/global
    // pointers so software can run without an init sequence.
    function automatic logic [DATA_W-1:0] reset_val(input int idx);
        logic [DATA_W-1:0] v;
        v = '0;
        if (idx == int'(REG_GP)) v = DATA_W'(GP_INIT);
        if (idx == int'(REG_SP)) v = DATA_W'(SP_INIT);
        return v;
    endfunction

    // Count up by one, holding at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction

    // A write only takes effect outside reset and never to $zero; with
    // RegWrite low an unknown wr_addr cannot make this true.
    assign wr_commit = RegWrite && !rst && !is_zero_reg(wr_addr);
    assign byp_en    = BYPASS && wr_commit;

    // Next-state for storage and debug tracking on a committed write
    always_comb begin
        regs_d      = regs_q;
        last_addr_d = last_addr_q;
        last_data_d = last_data_q;
        cnt_d       = cnt_q;
        if (wr_commit) begin
            regs_d[wr_addr] = wr_data;
            last_addr_d     = wr_addr;
            last_data_d     = wr_data;
            cnt_d           = sat_inc(cnt_q);
        end
    end

    // State register; reset overrides any write in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= reset_val(i);
            end
            last_addr_q <= '0;
            last_data_q <= '0;
            cnt_q       <= '0;
        end else begin
            regs_q      <= regs_d;
            last_addr_q <= last_addr_d;
            last_data_q <= last_data_d;
            cnt_q       <= cnt_d;
        end
    end

    // Flag an enabled write whose destination is unknown
    always_ff @(posedge clk) begin
        if (!rst && RegWrite) begin
            assert (!$isunknown(wr_addr));
        end
    end

    mips_reg_read_port #(.DATA_W(DATA_W)) u_rs_port (
        .addr_i     (rs_addr),
        .regs_i     (regs_q),
        .byp_en_i   (byp_en),
        .byp_addr_i (wr_addr),
        .byp_data_i (wr_data),
        .data_o     (rs_data)
    );

    mips_reg_read_port #(.DATA_W(DATA_W)) u_rt_port (
        .addr_i     (rt_addr),
        .regs_i     (regs_q),
        .byp_en_i   (byp_en),
        .byp_addr_i (wr_addr),
        .byp_data_i (wr_data),
        .data_o     (rt_data)
    );

    // Debug view always shows committed state, so forwarding is tied off
    mips_reg_read_port #(.DATA_W(DATA_W)) u_dbg_port (
        .addr_i     (dbg_addr),
        .regs_i     (regs_q),
        .byp_en_i   (1'b0),
        .byp_addr_i (5'd0),
        .byp_data_i ({DATA_W{1'b0}}),
        .data_o     (dbg_data)
    );

    assign last_wr_addr = last_addr_q;
    assign last_wr_data = last_data_q;
    assign wr_count     = cnt_q;

endmodule

// File: tb/tb_mips_reg_file.sv
// Directed testbench for mips_reg_file: one forwarding instance (BYPASS=1)
// and one write-then-read instance (BYPASS=0) driven by the same stimulus.
module tb_mips_reg_file;

    logic        clk;
    logic        rst;
    logic [4:0]  rs_addr, rt_addr, wr_addr, dbg_addr;
    logic [31:0] wr_data;
    logic        RegWrite;

    logic [31:0] rs_data, rt_data, dbg_data, last_wr_data;
    logic [4:0]  last_wr_addr;
    logic [15:0] wr_count;

    logic [31:0] rs_data0, rt_data0, dbg_data0, last_wr_data0;
    logic [4:0]  last_wr_addr0;
    logic [15:0] wr_count0;

    int errors = 0;
    int checks = 0;

    mips_reg_file #(.BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .wr_addr(wr_addr), .wr_data(wr_data), .RegWrite(RegWrite),
        .dbg_addr(dbg_addr), .rs_data(rs_data), .rt_data(rt_data),
        .dbg_data(dbg_data), .last_wr_addr(last_wr_addr),
        .last_wr_data(last_wr_data), .wr_count(wr_count)
    );

    mips_reg_file #(.BYPASS(1'b0)) dut0 (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .wr_addr(wr_addr), .wr_data(wr_data), .RegWrite(RegWrite),
        .dbg_addr(dbg_addr), .rs_data(rs_data0), .rt_data(rt_data0),
        .dbg_data(dbg_data0), .last_wr_addr(last_wr_addr0),
        .last_wr_data(last_wr_data0), .wr_count(wr_count0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] exp;
        rst = 1'b1; RegWrite = 1'b0; wr_addr = 5'd0; wr_data = '0;
        rs_addr = '0; rt_addr = '0; dbg_addr = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) begin
            rs_addr = 5'(i); rt_addr = 5'(31 - i); dbg_addr = 5'(i);
            #1;
            exp = (i == 28) ? 32'h1800 : (i == 29) ? 32'h3FFC : 32'h0;
            checks++; if (rs_data !== exp) begin errors++; $display("FAIL reset_rs[%0d] got=%h exp=%h", i, rs_data, exp); end
            checks++; if (dbg_data !== exp) begin errors++; $display("FAIL reset_dbg[%0d] got=%h exp=%h", i, dbg_data, exp); end
            exp = (31 - i == 28) ? 32'h1800 : (31 - i == 29) ? 32'h3FFC : 32'h0;
            checks++; if (rt_data !== exp) begin errors++; $display("FAIL reset_rt[%0d] got=%h exp=%h", 31 - i, rt_data, exp); end
        end
        checks++; if (wr_count !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", wr_count); end
        checks++; if (last_wr_addr !== 5'd0) begin errors++; $display("FAIL reset_last_addr got=%0d exp=0", last_wr_addr); end
        checks++; if (last_wr_data !== 32'd0) begin errors++; $display("FAIL reset_last_data got=%h exp=0", last_wr_data); end
    endtask

    task automatic test_write();
        RegWrite = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        tick();
        RegWrite = 1'b0; rs_addr = 5'd5; dbg_addr = 5'd5;
        #1;
        checks++; if (rs_data !== 32'hDEADBEEF) begin errors++; $display("FAIL write_rs got=%h exp=deadbeef", rs_data); end
        checks++; if (dbg_data !== 32'hDEADBEEF) begin errors++; $display("FAIL write_dbg got=%h exp=deadbeef", dbg_data); end
        checks++; if (last_wr_addr !== 5'd5) begin errors++; $display("FAIL write_last_addr got=%0d exp=5", last_wr_addr); end
        checks++; if (last_wr_data !== 32'hDEADBEEF) begin errors++; $display("FAIL write_last_data got=%h exp=deadbeef", last_wr_data); end
        checks++; if (wr_count !== 16'd1) begin errors++; $display("FAIL write_count got=%0d exp=1", wr_count); end
    endtask

    task automatic test_r0_and_jal();
        RegWrite = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
        rs_addr = 5'd0; rt_addr = 5'd0; dbg_addr = 5'd0;
        #1;
        checks++; if (rs_data !== 32'd0) begin errors++; $display("FAIL r0_nobypass got=%h exp=0", rs_data); end
        tick();
        RegWrite = 1'b0;
        #1;
        checks++; if (rs_data !== 32'd0) begin errors++; $display("FAIL r0_rs got=%h exp=0", rs_data); end
        checks++; if (dbg_data !== 32'd0) begin errors++; $display("FAIL r0_dbg got=%h exp=0", dbg_data); end
        checks++; if (wr_count !== 16'd1) begin errors++; $display("FAIL r0_count got=%0d exp=1", wr_count); end
        checks++; if (last_wr_addr !== 5'd5) begin errors++; $display("FAIL r0_last_addr got=%0d exp=5", last_wr_addr); end
        checks++; if (last_wr_data !== 32'hDEADBEEF) begin errors++; $display("FAIL r0_last_data got=%h exp=deadbeef", last_wr_data); end
        RegWrite = 1'b1; wr_addr = 5'd31; wr_data = 32'h0040_0008;
        tick();
        RegWrite = 1'b0; rt_addr = 5'd31;
        #1;
        checks++; if (rt_data !== 32'h0040_0008) begin errors++; $display("FAIL jal_rt got=%h exp=00400008", rt_data); end
        checks++; if (wr_count !== 16'd2) begin errors++; $display("FAIL jal_count got=%0d exp=2", wr_count); end
        checks++; if (last_wr_addr !== 5'd31) begin errors++; $display("FAIL jal_last_addr got=%0d exp=31", last_wr_addr); end
    endtask

    task automatic test_bypass();
        rs_addr = 5'd7; rt_addr = 5'd7; dbg_addr = 5'd7;
        RegWrite = 1'b1; wr_addr = 5'd7; wr_data = 32'h1234;
        #1;
        checks++; if (rs_data !== 32'h1234) begin errors++; $display("FAIL byp1_rs got=%h exp=1234", rs_data); end
        checks++; if (rt_data !== 32'h1234) begin errors++; $display("FAIL byp1_rt got=%h exp=1234", rt_data); end
        checks++; if (dbg_data !== 32'h0) begin errors++; $display("FAIL byp1_dbg got=%h exp=0", dbg_data); end
        checks++; if (rs_data0 !== 32'h0) begin errors++; $display("FAIL byp0_rs got=%h exp=0", rs_data0); end
        checks++; if (rt_data0 !== 32'h0) begin errors++; $display("FAIL byp0_rt got=%h exp=0", rt_data0); end
        tick();
        RegWrite = 1'b0;
        #1;
        checks++; if (rs_data !== 32'h1234) begin errors++; $display("FAIL post1_rs got=%h exp=1234", rs_data); end
        checks++; if (dbg_data !== 32'h1234) begin errors++; $display("FAIL post1_dbg got=%h exp=1234", dbg_data); end
        checks++; if (rs_data0 !== 32'h1234) begin errors++; $display("FAIL post0_rs got=%h exp=1234", rs_data0); end
        checks++; if (rt_data0 !== 32'h1234) begin errors++; $display("FAIL post0_rt got=%h exp=1234", rt_data0); end
        checks++; if (wr_count0 !== 16'd3) begin errors++; $display("FAIL post0_count got=%0d exp=3", wr_count0); end
    endtask

    task automatic test_idle_x();
        RegWrite = 1'b0; wr_addr = 'x; wr_data = 'x; dbg_addr = 5'd7;
        tick();
        tick();
        #1;
        checks++; if (wr_count !== 16'd3) begin errors++; $display("FAIL idle_count got=%0d exp=3", wr_count); end
        checks++; if (dbg_data !== 32'h1234) begin errors++; $display("FAIL idle_r7 got=%h exp=1234", dbg_data); end
        checks++; if (last_wr_addr !== 5'd7) begin errors++; $display("FAIL idle_last_addr got=%0d exp=7", last_wr_addr); end
    endtask

    task automatic test_rst_with_write();
        rst = 1'b1; RegWrite = 1'b1; wr_addr = 5'd9; wr_data = 32'hAA;
        rs_addr = 5'd9;
        #1;
        checks++; if (rs_data !== 32'h0) begin errors++; $display("FAIL rstw_nobypass got=%h exp=0", rs_data); end
        tick();
        rst = 1'b0; RegWrite = 1'b0; dbg_addr = 5'd9; rt_addr = 5'd29;
        #1;
        checks++; if (dbg_data !== 32'h0) begin errors++; $display("FAIL rstw_r9 got=%h exp=0", dbg_data); end
        checks++; if (wr_count !== 16'd0) begin errors++; $display("FAIL rstw_count got=%0d exp=0", wr_count); end
        checks++; if (last_wr_addr !== 5'd0) begin errors++; $display("FAIL rstw_last_addr got=%0d exp=0", last_wr_addr); end
        checks++; if (rt_data !== 32'h3FFC) begin errors++; $display("FAIL rstw_sp got=%h exp=3ffc", rt_data); end
        rs_addr = 5'd7;
        #1;
        checks++; if (rs_data !== 32'h0) begin errors++; $display("FAIL rstw_r7 got=%h exp=0", rs_data); end
    endtask

    task automatic test_saturate();
        RegWrite = 1'b1;
        for (int i = 0; i < 65534; i++) begin
            wr_addr = 5'((i % 31) + 1);
            wr_data = 32'(i);
            tick();
        end
        RegWrite = 1'b0;
        #1;
        checks++; if (wr_count !== 16'hFFFE) begin errors++; $display("FAIL sat_pre got=%h exp=fffe", wr_count); end
        RegWrite = 1'b1; wr_addr = 5'd10; wr_data = 32'h111;
        tick();
        checks++; if (wr_count !== 16'hFFFF) begin errors++; $display("FAIL sat_1 got=%h exp=ffff", wr_count); end
        wr_addr = 5'd11; wr_data = 32'h222;
        tick();
        checks++; if (wr_count !== 16'hFFFF) begin errors++; $display("FAIL sat_2 got=%h exp=ffff", wr_count); end
        wr_addr = 5'd12; wr_data = 32'h333;
        tick();
        RegWrite = 1'b0; rs_addr = 5'd12;
        #1;
        checks++; if (wr_count !== 16'hFFFF) begin errors++; $display("FAIL sat_3 got=%h exp=ffff", wr_count); end
        checks++; if (wr_count0 !== 16'hFFFF) begin errors++; $display("FAIL sat_b0 got=%h exp=ffff", wr_count0); end
        checks++; if (last_wr_addr !== 5'd12) begin errors++; $display("FAIL sat_last_addr got=%0d exp=12", last_wr_addr); end
        checks++; if (last_wr_data !== 32'h333) begin errors++; $display("FAIL sat_last_data got=%h exp=333", last_wr_data); end
        checks++; if (rs_data !== 32'h333) begin errors++; $display("FAIL sat_r12 got=%h exp=333", rs_data); end
    endtask

    initial begin
        rst = 1'b1; RegWrite = 1'b0; wr_addr = '0; wr_data = '0;
        rs_addr = '0; rt_addr = '0; dbg_addr = '0;
        test_reset();
        test_write();
        test_r0_and_jal();
        test_bypass();
        test_idle_x();
        test_rst_with_write();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
